// File: rtl/module_registros_arbiter_pkg.sv
// Shared types and constants for the two-requester register-bank arbiter.
//   state_t    : arbiter FSM states (IDLE, ACCESS, RESP)
//   REQ0/REQ1  : requester indices
//   SEL_R1/R2  : bank register select encodings
//   pick_owner : chooses the requester to grant from a request vector
//   sel_of     : bank register select requested by a given requester
package module_registros_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ0   = 1'b0;
  localparam logic REQ1   = 1'b1;
  localparam logic SEL_R1 = 1'b0;
  localparam logic SEL_R2 = 1'b1;

  // A lone requester always wins; a tie goes to the priority pointer.
  function automatic logic pick_owner(input logic [1:0] req, input logic ptr);
    logic owner;
    case (req)
      2'b01:   owner = REQ0;
      2'b10:   owner = REQ1;
      default: owner = ptr;
    endcase
    return owner;
  endfunction

  function automatic logic sel_of(input logic [1:0] sel, input logic owner);
    return sel[owner] ? SEL_R2 : SEL_R1;
  endfunction

endpackage

// File: rtl/module_registros_arbiter_if.sv
// Bundle of requester handshake signals and register-bank signals around the
// arbiter.
//   req_i/lock_i/we_i/sel_i : per-requester request, lock, write, register select
//   wdata0_i/wdata1_i       : per-requester write data
//   gnt_o/ack_o             : one-hot grant (ACCESS) and completion pulse (RESP)
//   rdata_o                 : bank data, nonzero only while ack_o is set
//   busy_o/timeout_o        : arbiter not idle / lock forcibly released
//   bank_*                  : single-port bank write/select/data, bank read data
// Modports: slave = arbiter side, master = requesters plus bank side.
interface module_registros_arbiter_if
  import module_registros_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [1:0]       req_i;
  logic [1:0]       lock_i;
  logic [1:0]       we_i;
  logic [1:0]       sel_i;
  logic [WIDTH-1:0] wdata0_i;
  logic [WIDTH-1:0] wdata1_i;
  logic [1:0]       gnt_o;
  logic [1:0]       ack_o;
  logic [WIDTH-1:0] rdata_o;
  logic             busy_o;
  logic             timeout_o;
  logic             bank_we_o;
  logic             bank_sel_o;
  logic [WIDTH-1:0] bank_wdata_o;
  logic [WIDTH-1:0] bank_rdata_i;

  modport slave (
    input  req_i, lock_i, we_i, sel_i, wdata0_i, wdata1_i, bank_rdata_i,
    output gnt_o, ack_o, rdata_o, busy_o, timeout_o,
           bank_we_o, bank_sel_o, bank_wdata_o
  );

  modport master (
    output req_i, lock_i, we_i, sel_i, wdata0_i, wdata1_i, bank_rdata_i,
    input  gnt_o, ack_o, rdata_o, busy_o, timeout_o,
           bank_we_o, bank_sel_o, bank_wdata_o
  );

endinterface

// File: rtl/module_lock_counter.sv
// Counts consecutive chained accesses of the current lock owner.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clear        : return count to zero (owner leaves, back to IDLE)
//   increment    : one more chained access
//   sat          : count has reached MAX_LOCK-1, no further chaining allowed
module module_lock_counter
  import module_registros_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic increment,
  output logic sat
);

  localparam int CW = $clog2(MAX_LOCK) + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_LOCK - 1);

  logic [CW-1:0] cnt_reg;

  // Saturates instead of wrapping so a stray increment can never reopen a lock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (increment && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign sat = (cnt_reg == LAST);

endmodule

// File: rtl/module_registros_arbiter.sv
// Round-robin arbiter/sequencer sharing a two-register bank between two
// requesters. Each grant performs one bank access: IDLE -> ACCESS (gnt_o,
// bank strobes) -> RESP (ack_o, rdata_o). A requester holding lock_i and
// req_i chains further accesses straight from RESP into ACCESS, up to
// MAX_LOCK accesses, after which the lock is broken with a timeout_o pulse.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : requester and bank signals (slave modport)
module module_registros_arbiter
  import module_registros_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  module_registros_arbiter_if.slave    bus
);

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   ptr_reg, ptr_next;
  logic   sel_reg, sel_next;
  logic   cnt_clear, cnt_inc, cnt_sat;
  logic   lock_hold;

  module_lock_counter #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear     (cnt_clear),
    .increment (cnt_inc),
    .sat       (cnt_sat)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      owner_reg <= REQ0;
      ptr_reg   <= REQ0;
      sel_reg   <= SEL_R1;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
    end
  end

  // All outputs decode from the registered state, so the asynchronous reset
  // forcing IDLE clears every output (including bank_we_o) at once.
  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    ptr_next         = ptr_reg;
    sel_next         = sel_reg;
    cnt_clear        = 1'b0;
    cnt_inc          = 1'b0;
    lock_hold        = bus.lock_i[owner_reg] & bus.req_i[owner_reg];
    bus.gnt_o        = 2'b00;
    bus.ack_o        = 2'b00;
    bus.rdata_o      = '0;
    bus.busy_o       = (state_reg != IDLE);
    bus.timeout_o    = 1'b0;
    bus.bank_we_o    = 1'b0;
    bus.bank_sel_o   = SEL_R1;
    bus.bank_wdata_o = '0;

    case (state_reg)
      IDLE: begin
        if (bus.req_i != 2'b00) begin
          owner_next = pick_owner(bus.req_i, ptr_reg);
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        bus.gnt_o[owner_reg] = 1'b1;
        bus.bank_sel_o       = sel_of(bus.sel_i, owner_reg);
        bus.bank_we_o        = bus.we_i[owner_reg];
        bus.bank_wdata_o     = (owner_reg == REQ1) ? bus.wdata1_i : bus.wdata0_i;
        // Keep the select for RESP so the read-back addresses the same register.
        sel_next             = sel_of(bus.sel_i, owner_reg);
        state_next           = RESP;
      end

      RESP: begin
        bus.ack_o[owner_reg] = 1'b1;
        bus.bank_sel_o       = sel_reg;
        bus.rdata_o          = bus.bank_rdata_i;
        if (lock_hold && !cnt_sat) begin
          cnt_inc    = 1'b1;
          state_next = ACCESS;
        end else begin
          // Lock still requested at the limit means it is being broken.
          bus.timeout_o = lock_hold;
          cnt_clear     = 1'b1;
          ptr_next      = ~owner_reg;
          state_next    = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_module_registros_arbiter.sv
// Testbench: transaction-level reference model feeding a scoreboard; a
// negedge monitor compares every ack against the queued expectation.
module tb_module_registros_arbiter;
  import module_registros_arbiter_pkg::*;

  localparam int WIDTH    = 32;
  localparam int MAX_LOCK = 4;

  typedef struct packed {
    logic             we;
    logic             sel;
    logic [WIDTH-1:0] data;
  } acc_t;

  typedef struct packed {
    logic             owner;
    logic [WIDTH-1:0] rdata;
    logic             tmo;
    int               gap;   // cycles since previous ack, 0 = unchecked
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  module_registros_arbiter_if #(.WIDTH(WIDTH)) bus ();

  module_registros_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Register bank behind the arbiter.
  logic [WIDTH-1:0] bank_mem [2] = '{default: '0};
  assign bus.bank_rdata_i = bank_mem[bus.bank_sel_o];
  always @(posedge clk_i) begin
    if (bus.bank_we_o) bank_mem[bus.bank_sel_o] <= bus.bank_wdata_o;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  acc_t drv0[$];
  acc_t drv1[$];
  exp_t sb[$];
  logic [WIDTH-1:0] ref_mem [2] = '{default: '0};
  logic       ref_ptr  = 1'b0;
  logic [1:0] lock_cfg = 2'b00;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic add_acc(input int r, input logic we, input logic sel, input logic [WIDTH-1:0] d);
    acc_t a;
    a.we = we; a.sel = sel; a.data = d;
    if (r == 0) drv0.push_back(a); else drv1.push_back(a);
  endtask

  // Reference model: serve pending accesses by the arbitration rules, at
  // transaction level, and queue the expected responses in grant order.
  task automatic model_round();
    acc_t m0[$];
    acc_t m1[$];
    acc_t a;
    exp_t e;
    int   own;
    int   cnt;
    bit   first;
    bit   chained;
    bit   more;
    m0 = drv0;
    m1 = drv1;
    first = 1'b1;
    while (m0.size() != 0 || m1.size() != 0) begin
      if (m0.size() != 0 && m1.size() != 0) own = int'(ref_ptr);
      else own = (m0.size() != 0) ? 0 : 1;
      cnt = 0;
      chained = 1'b0;
      do begin
        if (own == 0) a = m0.pop_front(); else a = m1.pop_front();
        cnt++;
        more = (own == 0) ? (m0.size() != 0) : (m1.size() != 0);
        if (a.we) ref_mem[a.sel] = a.data;
        e.owner = own[0];
        e.rdata = ref_mem[a.sel];
        e.tmo   = lock_cfg[own] && more && (cnt == MAX_LOCK);
        e.gap   = first ? 0 : (chained ? 2 : 3);
        sb.push_back(e);
        first   = 1'b0;
        chained = lock_cfg[own] && more && (cnt < MAX_LOCK);
      end while (chained);
      ref_ptr = (own == 0) ? 1'b1 : 1'b0;
    end
  endtask

  // Present requester r's head access, or release its request when empty.
  task automatic load(input int r);
    acc_t a;
    if (r == 0) begin
      if (drv0.size() == 0) begin
        bus.req_i[0] = 1'b0; bus.lock_i[0] = 1'b0;
      end else begin
        a = drv0[0];
        bus.req_i[0] = 1'b1; bus.lock_i[0] = lock_cfg[0];
        bus.we_i[0] = a.we; bus.sel_i[0] = a.sel; bus.wdata0_i = a.data;
      end
    end else begin
      if (drv1.size() == 0) begin
        bus.req_i[1] = 1'b0; bus.lock_i[1] = 1'b0;
      end else begin
        a = drv1[0];
        bus.req_i[1] = 1'b1; bus.lock_i[1] = lock_cfg[1];
        bus.we_i[1] = a.we; bus.sel_i[1] = a.sel; bus.wdata1_i = a.data;
      end
    end
  endtask

  task automatic drive_round(input int budget);
    int cyc;
    cyc = 0;
    model_round();
    load(0);
    load(1);
    while ((drv0.size() != 0 || drv1.size() != 0) && cyc < budget) begin
      @(posedge clk_i); #1;
      cyc++;
      if (bus.ack_o[0]) begin drv0.delete(0); load(0); end
      if (bus.ack_o[1]) begin drv1.delete(0); load(1); end
    end
    check("round_completed", 64'(drv0.size() + drv1.size()), 64'd0);
    if (drv0.size() + drv1.size() != 0) begin
      drv0.delete(); drv1.delete(); sb.delete();
      load(0); load(1);
    end
    lock_cfg = 2'b00;
    @(posedge clk_i); #1;
  endtask

  // Monitor: compares every ack against the scoreboard head.
  initial begin : monitor
    exp_t       e;
    logic [1:0] prev_gnt;
    int         cyc_cnt;
    int         last_ack;
    prev_gnt = 2'b00;
    cyc_cnt  = 0;
    last_ack = 0;
    forever begin
      @(negedge clk_i);
      cyc_cnt++;
      if (bus.ack_o != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 64'(bus.ack_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check("ack_owner", 64'(bus.ack_o), e.owner ? 64'd2 : 64'd1);
          check("ack_rdata", 64'(bus.rdata_o), 64'(e.rdata));
          check("ack_timeout", 64'(bus.timeout_o), 64'(e.tmo));
          check("gnt_before_ack", 64'(prev_gnt), 64'(bus.ack_o));
          if (e.gap != 0) check("ack_spacing", 64'(cyc_cnt - last_ack), 64'(e.gap));
        end
        last_ack = cyc_cnt;
      end else begin
        check("rdata_zero_without_ack", 64'(bus.rdata_o), 64'd0);
        check("timeout_without_ack", 64'(bus.timeout_o), 64'd0);
      end
      prev_gnt = bus.gnt_o;
    end
  end

  initial begin : main
    int   lk;
    int   n;
    bus.req_i = 2'b00; bus.lock_i = 2'b00; bus.we_i = 2'b00; bus.sel_i = 2'b00;
    bus.wdata0_i = '0; bus.wdata1_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_gnt", 64'(bus.gnt_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_bank_we", 64'(bus.bank_we_o), 64'd0);
    check("rst_bank_wdata", 64'(bus.bank_wdata_o), 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Single write with latency checks: gnt at cycle 1, ack at cycle 2
    add_acc(0, 1'b1, SEL_R2, 32'hDEADBEEF);
    model_round();
    load(0);
    @(posedge clk_i); #1;
    check("wr_gnt_cycle1", 64'(bus.gnt_o), 64'd1);
    check("wr_bank_we", 64'(bus.bank_we_o), 64'd1);
    check("wr_bank_sel", 64'(bus.bank_sel_o), 64'd1);
    check("wr_bank_wdata", 64'(bus.bank_wdata_o), 64'hDEADBEEF);
    @(posedge clk_i); #1;
    check("wr_ack_cycle2", 64'(bus.ack_o), 64'd1);
    check("wr_rdata", 64'(bus.rdata_o), 64'hDEADBEEF);
    drv0.delete(0);
    load(0);
    @(posedge clk_i); #1;
    check("wr_back_idle", 64'(bus.busy_o), 64'd0);

    // Read-back by requester 1
    add_acc(1, 1'b0, SEL_R2, 32'h0);
    drive_round(20);

    // Round-robin with both requesting continuously
    add_acc(0, 1'b0, SEL_R1, '0); add_acc(0, 1'b0, SEL_R2, '0);
    add_acc(1, 1'b0, SEL_R1, '0); add_acc(1, 1'b0, SEL_R2, '0);
    drive_round(30);

    // Pointer to requester 1, then locked burst by requester 1 while 0 waits
    add_acc(0, 1'b0, SEL_R1, '0);
    drive_round(20);
    lock_cfg = 2'b10;
    add_acc(1, 1'b1, SEL_R1, 32'h1); add_acc(1, 1'b1, SEL_R2, 32'h2);
    add_acc(1, 1'b1, SEL_R1, 32'h3);
    add_acc(0, 1'b0, SEL_R1, '0);
    drive_round(30);

    // Pointer to requester 0, then lock timeout: requester 0 wants 6 chained
    add_acc(1, 1'b0, SEL_R2, '0);
    drive_round(20);
    lock_cfg = 2'b01;
    for (int i = 0; i < 6; i++) add_acc(0, 1'b1, i[0], 32'h100 + i);
    add_acc(1, 1'b0, SEL_R1, '0);
    drive_round(60);

    // Request dropped during ACCESS: access still completes
    add_acc(0, 1'b1, SEL_R1, 32'hA5A5_5A5A);
    model_round();
    load(0);
    @(posedge clk_i); #1;
    check("drop_gnt", 64'(bus.gnt_o), 64'd1);
    bus.req_i[0] = 1'b0;
    @(posedge clk_i); #1;
    check("drop_ack", 64'(bus.ack_o), 64'd1);
    drv0.delete(0);
    load(0);
    @(posedge clk_i); #1;
    check("drop_back_idle", 64'(bus.busy_o), 64'd0);

    // Reset in the middle of a write access
    add_acc(0, 1'b1, SEL_R1, 32'h5555_5555);
    add_acc(1, 1'b1, SEL_R1, 32'h5555_5555);
    load(0); load(1);
    @(posedge clk_i); #1;
    check("pre_rst_bank_we", 64'(bus.bank_we_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_bank_we", 64'(bus.bank_we_o), 64'd0);
    check("mid_rst_gnt", 64'(bus.gnt_o), 64'd0);
    check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("mid_rst_bank_wdata", 64'(bus.bank_wdata_o), 64'd0);
    drv0.delete(); drv1.delete();
    load(0); load(1);
    ref_ptr = REQ0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    // Both request after reset: requester 0 must win; reg 1 keeps 0xA5A55A5A
    add_acc(0, 1'b0, SEL_R1, '0);
    add_acc(1, 1'b0, SEL_R1, '0);
    drive_round(20);

    // Randomized rounds
    for (int k = 0; k < 40; k++) begin
      lk = $urandom_range(0, 2);
      lock_cfg = (lk == 0) ? 2'b00 : ((lk == 1) ? 2'b01 : 2'b10);
      for (int r = 0; r < 2; r++) begin
        n = lock_cfg[r] ? $urandom_range(1, 7) : $urandom_range(0, 2);
        for (int i = 0; i < n; i++)
          add_acc(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
      if (drv0.size() + drv1.size() == 0) add_acc(1, 1'b0, SEL_R1, '0);
      drive_round(150);
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_registros_arbiter.md
Name: module_registros_arbiter

Overview:
- Arbiter and sequencer sharing one two-register, 32-bit register bank between two requesters (e.g. host bus and SPI engine).
- Grants one requester at a time, round-robin, with a req/gnt/ack handshake.
- Drives a single write or read per access into the bank.
- Supports locked back-to-back bursts, bounded by a lock-timeout counter.

Parameters:
WIDTH, 32, data width of bank and requester data paths
MAX_LOCK, 16, maximum consecutive accesses one owner may chain while lock_i is held (>=1)

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req_i  in  2  access request, bit n = requester n
lock_i  in  2  keep ownership after current access, bit n = requester n
we_i  in  2  1 = write, 0 = read, per requester
sel_i  in  2  register select per requester (0 = register 1, 1 = register 2)
wdata0_i  in  WIDTH  write data, requester 0
wdata1_i  in  WIDTH  write data, requester 1
gnt_o  out  2  one-hot grant, high during ACCESS
ack_o  out  2  one-cycle completion pulse, high during RESP
rdata_o  out  WIDTH  bank data, valid only while ack_o is nonzero, else 0
busy_o  out  1  state != IDLE
timeout_o  out  1  one-cycle pulse when a lock is forcibly released
bank_we_o  out  1  bank write enable
bank_sel_o  out  1  bank register select
bank_wdata_o  out  WIDTH  bank write data
bank_rdata_i  in  WIDTH  bank selected-register output (register updated on the clock edge after bank_we_o)

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - State = IDLE, priority pointer = requester 0, lock_cnt = 0, owner = 0.
  - All outputs = 0 immediately.
  - Reset mid-access abandons it: bank_we_o drops at once and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Outputs gnt_o, ack_o, bank_we_o = 0.
  - If req_i != 0, owner is chosen: only one bit set -> that requester; both set -> priority pointer.
  - Next state ACCESS, owner registered.
- ACCESS (exactly 1 cycle):
  - gnt_o[owner] = 1.
  - bank_sel_o = sel_i[owner], bank_we_o = we_i[owner], bank_wdata_o = owner's wdata.
  - Next state RESP unconditionally. Dropping req_i during ACCESS does not cancel the access.
- RESP (exactly 1 cycle):
  - ack_o[owner] = 1, bank_we_o = 0, bank_sel_o held, rdata_o = bank_rdata_i.
  - rdata_o therefore returns the post-write value on writes.
  - Transition rules:
    - lock_i[owner] & req_i[owner] & lock_cnt < MAX_LOCK-1 -> ACCESS, same owner, lock_cnt + 1.
    - lock_i[owner] & req_i[owner] & lock_cnt == MAX_LOCK-1 -> IDLE, timeout_o = 1 for this cycle.
    - otherwise -> IDLE.
  - On every return to IDLE: priority pointer = other requester, lock_cnt = 0.
- Latency:
  - req_i sampled in IDLE at cycle 0 -> gnt_o at cycle 1 -> ack_o at cycle 2.
  - Unlocked throughput: 3 cycles per access. Locked: 2 cycles per access.
- Requester obligation: hold req_i, we_i, sel_i and wdata stable from request until ack.
- bank_sel_o and bank_wdata_o are 0 in IDLE.
- lock_cnt width = clog2(MAX_LOCK) + 1. Comparisons are unsigned, with no wrap.
- Simultaneous requests after a burst: the other requester wins, so there is no starvation.
- lock_i of the non-owner is ignored.

Decomposition:
- Package module_registros_arbiter_pkg:
  - state_t enum {IDLE, ACCESS, RESP}.
  - Constants REQ0 = 0, REQ1 = 1, SEL_R1 = 0, SEL_R2 = 1.
- One sub-module, module_lock_counter:
  - Inputs: clear, increment.
  - Output: saturation flag at MAX_LOCK-1.
  - Reused for the timeout.

Test Plan:
- Reset: rst_i low mid-ACCESS with bank_we_o = 1 -> all outputs 0 the same cycle; after release, first req_i = 2'b11 grants requester 0.
- Single write then read:
  - Req 0 writes 0xDEADBEEF to sel = 1 -> gnt_o = 01 at cycle 1 and ack_o = 01 at cycle 2, with rdata_o = 0xDEADBEEF.
  - Then a read of sel = 1 by requester 1 returns 0xDEADBEEF.
- Round-robin: req_i held at 2'b11 for 12 cycles -> grants alternate 01, 10, 01, 10, at one access per 3 cycles.
- Locked burst: req 1 holds lock_i with 3 writes 0x1, 0x2, 0x3 while req 0 waits -> three consecutive ACCESS/RESP pairs with no IDLE gap, then req 0 granted.
- Lock timeout (MAX_LOCK = 4): req 0 locks indefinitely -> 4 accesses, timeout_o pulses on the 4th RESP, then req 1 granted.
- Request drop: req 0 deasserts during ACCESS -> write still lands and ack_o = 01 is still issued; FSM returns to IDLE.
